// File: rtl/floo_link_pkg.sv
// Shared widths and types for the inter-tile elastic link stage.
// Default payload widths come from the narrow/wide flit payload types.
package floo_link_pkg;

    typedef logic [63:0]  floo_req_payload_t;
    typedef logic [63:0]  floo_rsp_payload_t;
    typedef logic [575:0] floo_wide_payload_t;

    localparam int unsigned DefaultReqWidth  = $bits(floo_req_payload_t);
    localparam int unsigned DefaultRspWidth  = $bits(floo_rsp_payload_t);
    localparam int unsigned DefaultWideWidth = $bits(floo_wide_payload_t);
    localparam int unsigned DefaultCntWidth  = 32;

    typedef logic [DefaultCntWidth-1:0] link_cnt_t;

endpackage

// File: rtl/floo_link_fifo.sv
// One link channel: registered-output FIFO with no fall-through path, plus an optional
// saturating pop counter built only when FLOO_LINK_PERF_EN is defined.
module floo_link_fifo #(
    parameter int unsigned Width    = 64,
    parameter int unsigned Depth    = 2,
    parameter int unsigned CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [Width-1:0]    data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    data_o,
    output logic                empty_o,
    input  logic                cnt_clear_i,
    output logic [CntWidth-1:0] cnt_o
);

    localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CountWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    if (Depth < 2) begin : gen_depth_check
        $error("floo_link_fifo: Depth must be at least 2");
    end

    logic [Width-1:0]      mem_q [Depth];
    logic [PtrWidth-1:0]   rptr_q, rptr_d;
    logic [PtrWidth-1:0]   wptr_q, wptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  push, pop, full;

    assign full    = (count_q == FullCount);
    // Held low during reset so the upstream tile cannot push into a clearing stage.
    assign ready_o = ~full & ~rst_i;
    assign valid_o = (count_q != '0);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rptr_q];

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
        end
        if (push) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

`ifdef FLOO_LINK_PERF_EN
    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clear_i) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear_i;
    assign cnt_o            = '0;
`endif

endmodule

// File: rtl/floo_tile_link_buffer.sv
// Elastic link stage between two adjacent tiles: req and wide flow A->B, rsp flows B->A.
// Per-channel pop counters are present only when FLOO_LINK_PERF_EN is defined.
module floo_tile_link_buffer
    import floo_link_pkg::*;
#(
    parameter int unsigned ReqWidth  = DefaultReqWidth,
    parameter int unsigned RspWidth  = DefaultRspWidth,
    parameter int unsigned WideWidth = DefaultWideWidth,
    parameter int unsigned Depth     = 2,
    parameter int unsigned CntWidth  = DefaultCntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ReqWidth-1:0]  req_data_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [ReqWidth-1:0]  req_data_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [RspWidth-1:0]  rsp_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [RspWidth-1:0]  rsp_data_o,
    input  logic                 wide_valid_i,
    output logic                 wide_ready_o,
    input  logic [WideWidth-1:0] wide_data_i,
    output logic                 wide_valid_o,
    input  logic                 wide_ready_i,
    output logic [WideWidth-1:0] wide_data_o,
    output logic                 idle_o,
    input  logic                 cnt_clear_i,
    output logic [CntWidth-1:0]  req_cnt_o,
    output logic [CntWidth-1:0]  rsp_cnt_o,
    output logic [CntWidth-1:0]  wide_cnt_o
);

    logic req_empty, rsp_empty, wide_empty;

    floo_link_fifo #(
        .Width    (ReqWidth),
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) u_req_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (req_valid_i),
        .ready_o     (req_ready_o),
        .data_i      (req_data_i),
        .valid_o     (req_valid_o),
        .ready_i     (req_ready_i),
        .data_o      (req_data_o),
        .empty_o     (req_empty),
        .cnt_clear_i (cnt_clear_i),
        .cnt_o       (req_cnt_o)
    );

    // Response path runs from tile B back toward tile A.
    floo_link_fifo #(
        .Width    (RspWidth),
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (rsp_valid_i),
        .ready_o     (rsp_ready_o),
        .data_i      (rsp_data_i),
        .valid_o     (rsp_valid_o),
        .ready_i     (rsp_ready_i),
        .data_o      (rsp_data_o),
        .empty_o     (rsp_empty),
        .cnt_clear_i (cnt_clear_i),
        .cnt_o       (rsp_cnt_o)
    );

    floo_link_fifo #(
        .Width    (WideWidth),
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) u_wide_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (wide_valid_i),
        .ready_o     (wide_ready_o),
        .data_i      (wide_data_i),
        .valid_o     (wide_valid_o),
        .ready_i     (wide_ready_i),
        .data_o      (wide_data_o),
        .empty_o     (wide_empty),
        .cnt_clear_i (cnt_clear_i),
        .cnt_o       (wide_cnt_o)
    );

    assign idle_o = req_empty & rsp_empty & wide_empty;

endmodule

// File: tb/tb_floo_tile_link_buffer.sv
// Directed bench for floo_tile_link_buffer; counter expectations follow FLOO_LINK_PERF_EN.
module tb_floo_tile_link_buffer;

    localparam int unsigned ReqW  = 64;
    localparam int unsigned RspW  = 64;
    localparam int unsigned WideW = 576;
    localparam int unsigned CntW  = 32;

`ifdef FLOO_LINK_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_i, req_ready_o, req_valid_o, req_ready_i;
    logic [ReqW-1:0]  req_data_i, req_data_o;
    logic             rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
    logic [RspW-1:0]  rsp_data_i, rsp_data_o;
    logic             wide_valid_i, wide_ready_o, wide_valid_o, wide_ready_i;
    logic [WideW-1:0] wide_data_i, wide_data_o;
    logic             idle, cnt_clear;
    logic [CntW-1:0]  req_cnt, rsp_cnt, wide_cnt;

    // Second instance with 4-bit counters for saturation.
    logic             s_req_valid_i, s_req_ready_o, s_req_valid_o, s_req_ready_i;
    logic [7:0]       s_req_data_i, s_req_data_o;
    logic             s_rsp_ready_o, s_rsp_valid_o, s_wide_ready_o, s_wide_valid_o;
    logic [7:0]       s_rsp_data_o, s_wide_data_o;
    logic             s_idle;
    logic [3:0]       s_req_cnt, s_rsp_cnt, s_wide_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    floo_tile_link_buffer dut (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (req_valid_i), .req_ready_o (req_ready_o), .req_data_i (req_data_i),
        .req_valid_o (req_valid_o), .req_ready_i (req_ready_i), .req_data_o (req_data_o),
        .rsp_valid_i (rsp_valid_i), .rsp_ready_o (rsp_ready_o), .rsp_data_i (rsp_data_i),
        .rsp_valid_o (rsp_valid_o), .rsp_ready_i (rsp_ready_i), .rsp_data_o (rsp_data_o),
        .wide_valid_i (wide_valid_i), .wide_ready_o (wide_ready_o), .wide_data_i (wide_data_i),
        .wide_valid_o (wide_valid_o), .wide_ready_i (wide_ready_i), .wide_data_o (wide_data_o),
        .idle_o (idle), .cnt_clear_i (cnt_clear),
        .req_cnt_o (req_cnt), .rsp_cnt_o (rsp_cnt), .wide_cnt_o (wide_cnt)
    );

    floo_tile_link_buffer #(
        .ReqWidth (8), .RspWidth (8), .WideWidth (8), .Depth (2), .CntWidth (4)
    ) dut_sat (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (s_req_valid_i), .req_ready_o (s_req_ready_o), .req_data_i (s_req_data_i),
        .req_valid_o (s_req_valid_o), .req_ready_i (s_req_ready_i), .req_data_o (s_req_data_o),
        .rsp_valid_i (1'b0), .rsp_ready_o (s_rsp_ready_o), .rsp_data_i (8'h00),
        .rsp_valid_o (s_rsp_valid_o), .rsp_ready_i (1'b1), .rsp_data_o (s_rsp_data_o),
        .wide_valid_i (1'b0), .wide_ready_o (s_wide_ready_o), .wide_data_i (8'h00),
        .wide_valid_o (s_wide_valid_o), .wide_ready_i (1'b1), .wide_data_o (s_wide_data_o),
        .idle_o (s_idle), .cnt_clear_i (cnt_clear),
        .req_cnt_o (s_req_cnt), .rsp_cnt_o (s_rsp_cnt), .wide_cnt_o (s_wide_cnt)
    );

    function automatic logic [WideW-1:0] rand_wide();
        logic [WideW-1:0] r;
        for (int i = 0; i < WideW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        {req_valid_i, rsp_valid_i, wide_valid_i} = 3'b000;
        {req_ready_i, rsp_ready_i, wide_ready_i} = 3'b000;
        req_data_i = '0; rsp_data_i = '0; wide_data_i = '0; cnt_clear = 1'b0;
        s_req_valid_i = 1'b0; s_req_ready_i = 1'b0; s_req_data_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready_o, rsp_ready_o, wide_ready_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b want 000",
                               {req_ready_o, rsp_ready_o, wide_ready_o});
        end
        checks++;
        if ({req_valid_o, rsp_valid_o, wide_valid_o} !== 3'b000) begin
            errors++; $display("FAIL reset_valid: got %b want 000",
                               {req_valid_o, rsp_valid_o, wide_valid_o});
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL reset_idle: got %b want 1", idle);
        end
        checks++;
        if ({req_cnt, rsp_cnt, wide_cnt} !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0",
                               req_cnt, rsp_cnt, wide_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready_o, rsp_ready_o, wide_ready_o} !== 3'b111) begin
            errors++; $display("FAIL release_ready: got %b want 111",
                               {req_ready_o, rsp_ready_o, wide_ready_o});
        end
        checks++;
        if ({req_valid_o, rsp_valid_o, wide_valid_o, idle} !== 4'b0001) begin
            errors++; $display("FAIL release_state: got %b want 0001",
                               {req_valid_o, rsp_valid_o, wide_valid_o, idle});
        end
    endtask

    task automatic test_stream();
        req_ready_i = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            checks++;
            if (k == 0) begin
                if (req_valid_o !== 1'b0) begin
                    errors++; $display("FAIL stream_first_valid: got %b want 0", req_valid_o);
                end
            end else if (req_valid_o !== 1'b1 || req_data_o !== ReqW'(k - 1)) begin
                errors++; $display("FAIL stream_data[%0d]: got v=%b d=%0d want v=1 d=%0d",
                                   k, req_valid_o, req_data_o, k - 1);
            end
            if (k < 100) begin
                checks++;
                if (req_ready_o !== 1'b1) begin
                    errors++; $display("FAIL stream_ready[%0d]: got %b want 1", k, req_ready_o);
                end
                req_valid_i = 1'b1;
                req_data_i  = ReqW'(k);
            end else begin
                req_valid_i = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (req_valid_o !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL stream_drain: got v=%b idle=%b want v=0 idle=1",
                               req_valid_o, idle);
        end
        checks++;
        if (req_cnt !== (PerfEn ? CntW'(100) : CntW'(0))) begin
            errors++; $display("FAIL stream_cnt: got %0d want %0d", req_cnt, PerfEn ? 100 : 0);
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        req_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== (c < 2)) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, req_ready_o, c < 2);
            end
            if (c >= 1) begin
                checks++;
                if (req_valid_o !== 1'b1 || req_data_o !== ReqW'(200)) begin
                    errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d want v=1 d=200",
                                       c, req_valid_o, req_data_o);
                end
            end
            req_valid_i = 1'b1;
            req_data_i  = ReqW'(200 + accepted);
            if (c < 2) accepted++;
        end
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b0 || req_data_o !== ReqW'(200)) begin
            errors++; $display("FAIL bp_full: got r=%b d=%0d want r=0 d=200",
                               req_ready_o, req_data_o);
        end
        req_ready_i = 1'b1;
        req_data_i  = ReqW'(202);
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1 || req_valid_o !== 1'b1 || req_data_o !== ReqW'(201)) begin
            errors++; $display("FAIL bp_resume: got r=%b v=%b d=%0d want r=1 v=1 d=201",
                               req_ready_o, req_valid_o, req_data_o);
        end
        @(negedge clk);
        checks++;
        if (req_valid_o !== 1'b1 || req_data_o !== ReqW'(202)) begin
            errors++; $display("FAIL bp_next: got v=%b d=%0d want v=1 d=202",
                               req_valid_o, req_data_o);
        end
        req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid_o !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL bp_drain: got v=%b idle=%b want v=0 idle=1",
                               req_valid_o, idle);
        end
    endtask

    task automatic test_concurrent();
        logic [ReqW-1:0]  req_q[$];
        logic [RspW-1:0]  rsp_q[$];
        logic [WideW-1:0] wide_q[$];
        int n_req = 0, n_rsp = 0, n_wide = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc < 300) begin
                req_ready_i  = 1'($urandom_range(1)); req_valid_i  = 1'($urandom_range(1));
                rsp_ready_i  = 1'($urandom_range(1)); rsp_valid_i  = 1'($urandom_range(1));
                wide_ready_i = 1'($urandom_range(1)); wide_valid_i = 1'($urandom_range(1));
            end else begin
                {req_ready_i, rsp_ready_i, wide_ready_i} = 3'b111;
                {req_valid_i, rsp_valid_i, wide_valid_i} = 3'b000;
            end
            req_data_i  = {$urandom, $urandom};
            rsp_data_i  = {$urandom, $urandom};
            wide_data_i = rand_wide();
            if (req_valid_o && req_ready_i) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++; $display("FAIL conc_req_extra: got d=%h want no flit", req_data_o);
                end else if (req_data_o !== req_q.pop_front()) begin
                    errors++; $display("FAIL conc_req_data: got %h want queued flit", req_data_o);
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++; $display("FAIL conc_rsp_extra: got d=%h want no flit", rsp_data_o);
                end else if (rsp_data_o !== rsp_q.pop_front()) begin
                    errors++; $display("FAIL conc_rsp_data: got %h want queued flit", rsp_data_o);
                end
            end
            if (wide_valid_o && wide_ready_i) begin
                checks++;
                if (wide_q.size() == 0) begin
                    errors++; $display("FAIL conc_wide_extra: got flit want no flit");
                end else if (wide_data_o !== wide_q.pop_front()) begin
                    errors++; $display("FAIL conc_wide_data: got %h want queued flit",
                                       wide_data_o[63:0]);
                end
            end
            if (req_valid_i && req_ready_o) begin req_q.push_back(req_data_i); n_req++; end
            if (rsp_valid_i && rsp_ready_o) begin rsp_q.push_back(rsp_data_i); n_rsp++; end
            if (wide_valid_i && wide_ready_o) begin wide_q.push_back(wide_data_i); n_wide++; end
        end
        checks++;
        if (req_q.size() != 0 || rsp_q.size() != 0 || wide_q.size() != 0 || idle !== 1'b1) begin
            errors++; $display("FAIL conc_leftover: got %0d %0d %0d idle=%b want 0 0 0 idle=1",
                               req_q.size(), rsp_q.size(), wide_q.size(), idle);
        end
        checks++;
        if (n_req < 40 || n_rsp < 40 || n_wide < 40) begin
            errors++; $display("FAIL conc_traffic: got %0d %0d %0d accepts want >= 40 each",
                               n_req, n_rsp, n_wide);
        end
    endtask

    task automatic test_reset_mid();
        req_ready_i = 1'b0;
        @(negedge clk); req_valid_i = 1'b1; req_data_i = ReqW'(64'hAA);
        @(negedge clk); req_data_i = ReqW'(64'hBB);
        @(negedge clk); req_valid_i = 1'b0;
        checks++;
        if (req_valid_o !== 1'b1 || req_ready_o !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: got v=%b r=%b idle=%b want v=1 r=0 idle=0",
                               req_valid_o, req_ready_o, idle);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req_valid_o !== 1'b0 || idle !== 1'b1 || req_ready_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got v=%b idle=%b r=%b want v=0 idle=1 r=0",
                               req_valid_o, idle, req_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        req_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_valid_o !== 1'b0) begin
                errors++; $display("FAIL rstmid_stale[%0d]: got v=%b d=%h want v=0",
                                   c, req_valid_o, req_data_o);
            end
        end
        req_valid_i = 1'b1; req_data_i = ReqW'(64'hCC);
        @(negedge clk);
        req_valid_i = 1'b0;
        checks++;
        if (req_valid_o !== 1'b1 || req_data_o !== ReqW'(64'hCC)) begin
            errors++; $display("FAIL rstmid_fresh: got v=%b d=%h want v=1 d=cc",
                               req_valid_o, req_data_o);
        end
        @(negedge clk);
    endtask

    task automatic test_counters();
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        checks++;
        if ({req_cnt, rsp_cnt, wide_cnt} !== '0) begin
            errors++; $display("FAIL cnt_clear: got %0d %0d %0d want 0 0 0",
                               req_cnt, rsp_cnt, wide_cnt);
        end
        wide_ready_i = 1'b1;
        for (int k = 0; k < 37; k++) begin
            wide_valid_i = 1'b1;
            wide_data_i  = rand_wide();
            @(negedge clk);
        end
        wide_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (wide_cnt !== (PerfEn ? CntW'(37) : CntW'(0)) || req_cnt !== '0 || rsp_cnt !== '0)
        begin
            errors++; $display("FAIL cnt_wide37: got %0d (req %0d rsp %0d) want %0d",
                               wide_cnt, req_cnt, rsp_cnt, PerfEn ? 37 : 0);
        end
        wide_valid_i = 1'b1;
        @(negedge clk);
        wide_valid_i = 1'b0;
        cnt_clear    = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        checks++;
        if (wide_cnt !== '0 || wide_valid_o !== 1'b0) begin
            errors++; $display("FAIL cnt_clear_pop: got cnt=%0d v=%b want cnt=0 v=0",
                               wide_cnt, wide_valid_o);
        end
        s_req_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s_req_valid_i = 1'b1;
            s_req_data_i  = 8'(k);
            @(negedge clk);
        end
        s_req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s_req_cnt !== (PerfEn ? 4'd15 : 4'd0) || s_rsp_cnt !== 4'd0 || s_wide_cnt !== 4'd0)
        begin
            errors++; $display("FAIL cnt_saturate: got %0d %0d %0d want %0d 0 0",
                               s_req_cnt, s_rsp_cnt, s_wide_cnt, PerfEn ? 15 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_concurrent();
        test_reset_mid();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
